// File: rtl/ifid_stall_stage_pkg.sv
// Shared pipeline definitions for the IF/ID stall stage: datapath width,
// the NOP word used to clear the IF/ID slot, and the stall FSM states.
package ifid_stall_stage_pkg;

  localparam int          PKG_DW        = 32;
  localparam logic [31:0] PKG_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

endpackage

// File: rtl/ifid_stall_stage_stall_monitor.sv
// Stall statistics: saturating total stall counter, consecutive-run tracker
// and a sticky flag for stall runs longer than MAX_STALL cycles.
module stall_monitor
  import ifid_stall_stage_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_q,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  localparam int                RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0]  RUN_LIM = RUN_W'(MAX_STALL);

  stall_state_e     state_q;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_inc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_q;

  // Run counter stops one past the limit so it can never wrap back into range.
  assign run_inc_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
  assign cnt_d     = (stall_q && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      run_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_RUN: begin
          if (stall_q) begin
            state_q <= ST_STALL;
            run_q   <= RUN_W'(1);
          end else begin
            run_q   <= '0;
          end
        end
        ST_STALL: begin
          if (flush) begin
            state_q <= ST_RUN;
            run_q   <= '0;
          end else if (stall_q) begin
            run_q   <= run_inc_d;
            if (run_q == RUN_LIM) timeout_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
            run_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          run_q   <= '0;
        end
      endcase
    end
  end

  assign stall_cnt     = cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: rtl/ifid_stall_stage.sv
// IF/ID pipeline register with data-hazard stall, EX redirect flush and
// ID/EX bubble injection; stall statistics live in stall_monitor.
module ifid_stall_stage
  import ifid_stall_stage_pkg::*;
#(
  parameter int              DW        = PKG_DW,
  parameter int              CNT_W     = 32,
  parameter int              MAX_STALL = 2,
  parameter logic [DW-1:0]   NOP_INSTR = PKG_NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bb_data,
  input  logic             flush,
  input  logic [DW-1:0]    if_pc,
  input  logic [DW-1:0]    if_instr,
  input  logic             if_valid,
  output logic             pc_en,
  output logic [DW-1:0]    id_pc,
  output logic [DW-1:0]    id_instr,
  output logic             id_valid,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  logic [DW-1:0] id_pc_q,    id_pc_d;
  logic [DW-1:0] id_instr_q, id_instr_d;
  logic          id_valid_q, id_valid_d;
  logic          stall_q;

  // A hazard against an empty or killed ID slot has nothing to protect.
  assign stall_q = bb_data & id_valid_q & ~flush;

  assign pc_en       = ~stall_q;
  assign idex_bubble = ~rst & (stall_q | flush | ~id_valid_q);

  always_comb begin
    id_pc_d    = if_pc;
    id_instr_d = if_instr;
    id_valid_d = if_valid;
    if (flush) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
    end else if (stall_q) begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_valid = id_valid_q;

  stall_monitor #(
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) u_stall_monitor (
    .clk           (clk),
    .rst           (rst),
    .stall_q       (stall_q),
    .flush         (flush),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_ifid_stall_stage.sv
// Self-checking bench: table-driven vectors with a scoreboard of post-edge
// expectations, plus hand sequences for async reset and counter saturation.
module tb_ifid_stall_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, 32-bit stall counter.
  logic        rst, bb_data, flush, if_valid;
  logic [31:0] if_pc, if_instr;
  logic        pc_en, id_valid, idex_bubble, stall_timeout;
  logic [31:0] id_pc, id_instr, stall_cnt;

  ifid_stall_stage dut (
    .clk(clk), .rst(rst), .bb_data(bb_data), .flush(flush),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .pc_en(pc_en), .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
    .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  // Second instance, 4-bit counter for saturation.
  logic        rst2, bb2, flush2, valid2;
  logic [31:0] pc2, instr2;
  logic        pc_en2, id_valid2, bub2, to2;
  logic [31:0] id_pc2, id_instr2;
  logic [3:0]  cnt2;

  ifid_stall_stage #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .bb_data(bb2), .flush(flush2),
    .if_pc(pc2), .if_instr(instr2), .if_valid(valid2),
    .pc_en(pc_en2), .id_pc(id_pc2), .id_instr(id_instr2), .id_valid(id_valid2),
    .idex_bubble(bub2), .stall_cnt(cnt2), .stall_timeout(to2)
  );

  typedef struct {
    logic        bb, fl, v;
    logic [31:0] pc;
    logic        e_pc_en, e_bub;
    logic [31:0] e_id_pc, e_id_instr;
    logic        e_id_v;
    logic [31:0] e_cnt;
    logic        e_to;
  } vec_t;

  typedef struct {
    logic [31:0] id_pc, id_instr, cnt;
    logic        id_v, to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic bb, input logic fl, input logic [31:0] pc, input logic v,
                     input logic e_pc_en, input logic e_bub, input logic [31:0] e_id_pc,
                     input logic [31:0] e_id_instr, input logic e_id_v,
                     input logic [31:0] e_cnt, input logic e_to);
    vec_t t;
    t.bb = bb; t.fl = fl; t.pc = pc; t.v = v;
    t.e_pc_en = e_pc_en; t.e_bub = e_bub; t.e_id_pc = e_id_pc;
    t.e_id_instr = e_id_instr; t.e_id_v = e_id_v; t.e_cnt = e_cnt; t.e_to = e_to;
    vecs.push_back(t);
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  initial begin
    exp_t e;
    rst = 1'b1; bb_data = 0; flush = 0; if_pc = 0; if_instr = 0; if_valid = 0;
    rst2 = 1'b1; bb2 = 0; flush2 = 0; pc2 = 0; instr2 = 0; valid2 = 0;

    //   bb fl pc     v  pc_en bub id_pc  id_instr       id_v cnt to
    add(0, 0, 32'h00, 1, 1, 1, 32'h00, 32'hA000_0000, 1, 0, 0);
    add(0, 0, 32'h04, 1, 1, 0, 32'h04, 32'hA000_0004, 1, 0, 0);
    add(1, 0, 32'h08, 1, 0, 1, 32'h04, 32'hA000_0004, 1, 1, 0);
    add(1, 0, 32'h08, 1, 0, 1, 32'h04, 32'hA000_0004, 1, 2, 0);
    add(0, 0, 32'h08, 1, 1, 0, 32'h08, 32'hA000_0008, 1, 2, 0);
    add(1, 1, 32'h0C, 1, 1, 1, 32'h0C, 32'h0000_0000, 0, 2, 0);
    add(1, 0, 32'h10, 1, 1, 1, 32'h10, 32'hA000_0010, 1, 2, 0);
    add(1, 0, 32'h14, 1, 0, 1, 32'h10, 32'hA000_0010, 1, 3, 0);
    add(1, 0, 32'h14, 1, 0, 1, 32'h10, 32'hA000_0010, 1, 4, 0);
    add(1, 0, 32'h14, 1, 0, 1, 32'h10, 32'hA000_0010, 1, 5, 1);
    add(0, 0, 32'h14, 1, 1, 0, 32'h14, 32'hA000_0014, 1, 5, 1);
    add(0, 0, 32'h18, 0, 1, 0, 32'h18, 32'hA000_0018, 0, 5, 1);
    add(0, 0, 32'h1C, 1, 1, 1, 32'h1C, 32'hA000_001C, 1, 5, 1);
    add(1, 0, 32'h20, 1, 0, 1, 32'h1C, 32'hA000_001C, 1, 6, 1);
    add(1, 1, 32'h20, 1, 1, 1, 32'h20, 32'h0000_0000, 0, 6, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_en", pc_en, 1);
    chk("rst_bubble", idex_bubble, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_timeout", stall_timeout, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bb_data = vecs[i].bb; flush = vecs[i].fl;
      if_pc = vecs[i].pc; if_instr = ins(vecs[i].pc); if_valid = vecs[i].v;
      #1;
      chk($sformatf("v%0d_pc_en", i), pc_en, vecs[i].e_pc_en);
      chk($sformatf("v%0d_bubble", i), idex_bubble, vecs[i].e_bub);
      e.id_pc = vecs[i].e_id_pc; e.id_instr = vecs[i].e_id_instr;
      e.id_v = vecs[i].e_id_v; e.cnt = vecs[i].e_cnt; e.to = vecs[i].e_to;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_id_pc", i), id_pc, e.id_pc);
      chk($sformatf("v%0d_id_instr", i), id_instr, e.id_instr);
      chk($sformatf("v%0d_id_valid", i), id_valid, e.id_v);
      chk($sformatf("v%0d_cnt", i), stall_cnt, e.cnt);
      chk($sformatf("v%0d_timeout", i), stall_timeout, e.to);
      $display("vec %0d: bb=%0b fl=%0b pc=%08h -> id_pc=%08h id_v=%0b cnt=%0d to=%0b",
               i, vecs[i].bb, vecs[i].fl, vecs[i].pc, id_pc, id_valid, stall_cnt, stall_timeout);
    end

    // Async reset in the middle of a stall.
    @(negedge clk);
    bb_data = 0; flush = 0; if_pc = 32'h24; if_instr = ins(32'h24); if_valid = 1;
    @(negedge clk);
    bb_data = 1; if_pc = 32'h28; if_instr = ins(32'h28);
    #1;
    chk("mid_pc_en_stalled", pc_en, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_id_pc", id_pc, 0);
    chk("arst_id_instr", id_instr, 0);
    chk("arst_id_valid", id_valid, 0);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_timeout", stall_timeout, 0);
    chk("arst_pc_en", pc_en, 1);
    chk("arst_bubble", idex_bubble, 0);
    $display("async reset: id_pc=%08h id_v=%0b cnt=%0d to=%0b", id_pc, id_valid, stall_cnt, stall_timeout);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_id_pc", id_pc, 32'h28);
    chk("post_rst_id_instr", id_instr, 32'hA000_0028);
    chk("post_rst_id_valid", id_valid, 1);
    chk("post_rst_cnt", stall_cnt, 0);
    $display("post reset load: id_pc=%08h id_v=%0b", id_pc, id_valid);

    // Saturation of a 4-bit counter over 20 stall cycles.
    @(negedge clk);
    rst2 = 1'b0; pc2 = 32'h40; instr2 = ins(32'h40); valid2 = 1;
    @(negedge clk);
    bb2 = 1; pc2 = 32'h44; instr2 = ins(32'h44);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt_%0d", k), {28'd0, cnt2}, (k > 15) ? 32'd15 : 32'(k));
      chk($sformatf("sat_id_pc_%0d", k), id_pc2, 32'h40);
      $display("sat cycle %0d: cnt=%0h to=%0b", k, cnt2, to2);
    end
    chk("sat_timeout", to2, 1);
    @(negedge clk);
    bb2 = 0;
    @(posedge clk);
    #1;
    chk("sat_release_id_pc", id_pc2, 32'h44);
    chk("sat_hold_cnt", {28'd0, cnt2}, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
